// File: rtl/rf_pkg.sv
// Shared constants, word/address types and reader FSM encoding for the 8x32 register file.
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 4;

  typedef logic [DATA_W-1:0] rf_word_t;
  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [CNT_W-1:0]  rf_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rd_state_t;

  // A scan never reads more words than the file holds.
  function automatic rf_cnt_t clamp_count(input rf_cnt_t c);
    return (c > rf_cnt_t'(NUM_REGS)) ? rf_cnt_t'(NUM_REGS) : c;
  endfunction
endpackage

// File: rtl/rf_addr_walker.sv
// Scan pointer and remaining-word counter; pointer wraps modulo NUM_REGS on each step.
// Load and step are registered; last_o flags the final word of the scan.
module rf_addr_walker
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              last_o
);
  rf_addr_t ptr_q, ptr_d;
  rf_cnt_t  rem_q, rem_d;

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load_i) begin
      ptr_d = load_addr_i;
      rem_d = clamp_count(load_cnt_i);
    end else if (step_i) begin
      ptr_d = ptr_q + rf_addr_t'(1);
      rem_d = rem_q - rf_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (rem_q == rf_cnt_t'(1));
endmodule

// File: rtl/rf_stream_reader.sv
// Streams a wrapping register-file range out on valid/ready, 1 word per 2 cycles; holds word under backpressure.
// Optional RF_STREAM_CHECKSUM_EN adds chk, an XOR of all words handed off in the current scan.
module rf_stream_reader
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef RF_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);
  rd_state_t state_q, state_d;
  rf_word_t  data_q;
  rf_addr_t  addr_q;
  rf_addr_t  ptr;
  logic      valid_q, busy_q, done_q;
  logic      load, hs, last;

  assign load = (state_q == IDLE) && start;
  assign hs   = (state_q == SEND) && valid_q && out_ready;

  rf_addr_walker u_walker (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .load_addr_i(first_addr),
    .load_cnt_i (count),
    .step_i     (hs),
    .ptr_o      (ptr),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (count == '0) ? DONE : READ;
      READ: state_d = SEND;
      SEND: if (hs) state_d = last ? DONE : READ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_q == READ) begin
        data_q  <= rData;
        addr_q  <= ptr;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef RF_STREAM_CHECKSUM_EN
  rf_word_t chk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= '0;
    end else if (load) begin
      chk_q <= '0;
    end else if (hs) begin
      chk_q <= chk_q ^ data_q;
    end
  end

  assign chk = chk_q;
`endif

  assign rAddr     = ptr;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_rf_stream_reader.sv
// Randomized bench for rf_stream_reader against a queue-based scan model; covers RF_STREAM_CHECKSUM_EN when defined.
module tb_rf_stream_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  first_addr = '0;
  logic [3:0]  count = '0;
  logic [2:0]  rAddr;
  logic [31:0] rData;
  logic [31:0] out_data;
  logic [2:0]  out_addr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef RF_STREAM_CHECKSUM_EN
  logic [31:0] chk;
`endif
  logic [31:0] rf [8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rData = rf[rAddr];

  rf_stream_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .first_addr(first_addr),
    .count     (count),
    .rAddr     (rAddr),
    .rData     (rData),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef RF_STREAM_CHECKSUM_EN
    ,
    .chk       (chk)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_raddr"}, rAddr, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, out_addr, 0);
`ifdef RF_STREAM_CHECKSUM_EN
    check({tag, "_chk"}, chk, 0);
`endif
  endtask

  // mode 0: always ready (exact timing checked), 1: random ready, 2: stall first word 5 cycles
  task automatic run_scan(input int first, input int cnt, input int mode, input bit poke_start);
    int n, k, hold, cyc;
    bit done_seen, pending;
    logic [2:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] exp_chk, last_d;
    logic [2:0]  last_a;
    n = (cnt > 8) ? 8 : cnt;
    exp_chk = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(3'((first + i) % 8));
      exp_data.push_back(rf[(first + i) % 8]);
      exp_chk ^= rf[(first + i) % 8];
    end
    @(negedge clk);
    first_addr = 3'(first);
    count = 4'(cnt);
    start = 1'b1;
    out_ready = 1'b0;
    k = 0; hold = 0; pending = 0; done_seen = 0; last_d = 0; last_a = 0;
    for (cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) begin
        check("busy_after_start", busy, 1);
        if (n > 0) check("no_valid_in_read", out_valid, 0);
`ifdef RF_STREAM_CHECKSUM_EN
        check("chk_cleared", chk, 0);
`endif
      end
      if (mode == 0 && cyc == 1 && n > 0) check("first_valid_latency", out_valid, 1);
      if (pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, last_d);
        check("hold_addr", out_addr, last_a);
      end
      pending = 0;
      if (done) begin
        done_seen = 1;
        check("word_count", k, n);
        check("busy_at_done", busy, 1);
        check("valid_at_done", out_valid, 0);
        if (mode == 0) check("done_cycle", cyc, 2 * n);
`ifdef RF_STREAM_CHECKSUM_EN
        check("chk_at_done", chk, exp_chk);
`endif
      end else if (out_valid) begin
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        else begin
          out_ready = (hold >= 5);
          hold++;
        end
        if (out_ready) begin
          if (k < n) begin
            check("word_addr", out_addr, exp_addr[k]);
            check("word_data", out_data, exp_data[k]);
          end else check("extra_word", k, n);
          k++;
        end else begin
          pending = 1;
          last_d = out_data;
          last_a = out_addr;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (poke_start && !done && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        first_addr = 3'($urandom);
        count = 4'($urandom);
      end
    end
    if (!done_seen) check("scan_timeout", 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("valid_after_done", out_valid, 0);
`ifdef RF_STREAM_CHECKSUM_EN
    check("chk_stable", chk, exp_chk);
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 32'h1000_0000 + i;
    #2 reset_n = 1'b0;
    #1 check_idle_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_scan(0, 8, 0, 0);
    run_scan(6, 4, 0, 0);
    run_scan(0, 0, 0, 0);
    run_scan(5, 12, 0, 0);
    run_scan(2, 6, 2, 1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) rf[i] = $urandom;
      run_scan($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 2), 1);
    end

    // Asynchronous reset while the first word is stalled in SEND.
    @(negedge clk);
    first_addr = 3'd0; count = 4'd8; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1 check_idle_zero("midscan_reset");
    @(negedge clk);
    check_idle_zero("reset_no_done");
    reset_n = 1'b1;
    run_scan(3, 2, 0, 0);

`ifdef RF_STREAM_CHECKSUM_EN
    rf[0] = 32'h1; rf[1] = 32'h2; rf[2] = 32'h4; rf[3] = 32'h8;
    run_scan(0, 4, 0, 0);
    run_scan(1, 2, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
